sel_box_render: RTL and testbench

SEL_BOX_RENDER -- requirements
Module: sel_box_render

---
 rtl/sel_box_render.sv | 187 ++++++++++++++++++
 tb/tb_sel_box_render.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sel_box_render.sv
// sel_box_render: draws a square cell outline on a pixel grid, one pixel per
// cycle. Before drawing it can erase the box drawn last time, using the
// background colour.
module sel_box_render #(
    parameter int BOX_SIZE = 26,
    parameter int GRID_N   = 8,
    parameter int IDX_W    = 3,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [8:0]          base_x,
    input  logic [7:0]          base_y,
    input  logic [IDX_W-1:0]    box_x,
    input  logic [IDX_W-1:0]    box_y,
    input  logic                mode,
    input  logic [COLOUR_W-1:0] draw_colour,
    input  logic [COLOUR_W-1:0] bg_colour,
    output logic [8:0]          x,
    output logic [7:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                writeEn,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    localparam logic [5:0] K_LAST = 6'(BOX_SIZE - 2);
    localparam logic [8:0] SX     = 9'(BOX_SIZE - 1);
    localparam logic [7:0] SY     = 8'(BOX_SIZE - 1);

    state_t              state, state_n;
    logic [1:0]          e, e_n;
    logic [5:0]          k, k_n;
    logic [8:0]          new_ox, prev_ox, pix_ox, nx;
    logic [7:0]          new_oy, prev_oy, pix_oy, ny;
    logic [COLOUR_W-1:0] drw_col, bg_col, pix_col;
    logic [IDX_W-1:0]    cx, cy;
    logic                prev_valid, we_n, last;

    // Perimeter walk: edge e, step k, relative to origin.
    function automatic logic [8:0] pix_x(input logic [8:0] ox, input logic [1:0] ed,
                                         input logic [5:0] st);
        case (ed)
            2'd0:    return ox + 9'(st);
            2'd1:    return ox + SX;
            2'd2:    return ox + SX - 9'(st);
            default: return ox;
        endcase
    endfunction

    function automatic logic [7:0] pix_y(input logic [7:0] oy, input logic [1:0] ed,
                                         input logic [5:0] st);
        case (ed)
            2'd0:    return oy;
            2'd1:    return oy + 8'(st);
            2'd2:    return oy + SY;
            default: return oy + SY - 8'(st);
        endcase
    endfunction

    // Clamp the requested cell and turn it into a pixel origin (wraps on overflow).
    always_comb begin
        cx = (int'(box_x) >= GRID_N) ? IDX_W'(GRID_N - 1) : box_x;
        cy = (int'(box_y) >= GRID_N) ? IDX_W'(GRID_N - 1) : box_y;
        nx = 9'(int'(base_x) + int'(cx) * BOX_SIZE);
        ny = 8'(int'(base_y) + int'(cy) * BOX_SIZE);
    end

    // Next state, next walk position and the pixel to present next cycle.
    always_comb begin
        state_n = state;
        e_n     = e;
        k_n     = k;
        we_n    = 1'b0;
        pix_ox  = new_ox;
        pix_oy  = new_oy;
        pix_col = drw_col;
        last    = (e == 2'd3) && (k == K_LAST);
        case (state)
            IDLE: begin
                if (start) begin
                    e_n  = 2'd0;
                    k_n  = 6'd0;
                    we_n = 1'b1;
                    if (!mode && prev_valid) begin
                        state_n = ERASE;
                        pix_ox  = prev_ox;
                        pix_oy  = prev_oy;
                        pix_col = bg_colour;
                    end else begin
                        state_n = DRAW;
                        pix_ox  = nx;
                        pix_oy  = ny;
                        pix_col = draw_colour;
                    end
                end
            end
            ERASE: begin
                we_n    = 1'b1;
                pix_ox  = prev_ox;
                pix_oy  = prev_oy;
                pix_col = bg_col;
                if (last) begin
                    // Hand over straight to the draw pass, no gap cycle.
                    state_n = DRAW;
                    e_n     = 2'd0;
                    k_n     = 6'd0;
                    pix_ox  = new_ox;
                    pix_oy  = new_oy;
                    pix_col = drw_col;
                end else if (k == K_LAST) begin
                    e_n = e + 2'd1;
                    k_n = 6'd0;
                end else begin
                    k_n = k + 6'd1;
                end
            end
            DRAW: begin
                if (last) begin
                    state_n = DONE;
                    e_n     = 2'd0;
                    k_n     = 6'd0;
                end else begin
                    we_n = 1'b1;
                    if (k == K_LAST) begin
                        e_n = e + 2'd1;
                        k_n = 6'd0;
                    end else begin
                        k_n = k + 6'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, walk counters, latched request and registered pixel outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            e          <= 2'd0;
            k          <= 6'd0;
            new_ox     <= 9'd0;
            new_oy     <= 8'd0;
            prev_ox    <= 9'd0;
            prev_oy    <= 8'd0;
            prev_valid <= 1'b0;
            drw_col    <= '0;
            bg_col     <= '0;
            x          <= 9'd0;
            y          <= 8'd0;
            colour     <= '0;
            writeEn    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state   <= state_n;
            e       <= e_n;
            k       <= k_n;
            writeEn <= we_n;
            busy    <= (state_n != IDLE);
            done    <= (state_n == DONE);
            if (we_n) begin
                x      <= pix_x(pix_ox, e_n, k_n);
                y      <= pix_y(pix_oy, e_n, k_n);
                colour <= pix_col;
            end
            if (state == IDLE && start) begin
                new_ox  <= nx;
                new_oy  <= ny;
                drw_col <= draw_colour;
                bg_col  <= bg_colour;
            end
            if (state == DONE) begin
                prev_ox    <= new_ox;
                prev_oy    <= new_oy;
                prev_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sel_box_render.sv
// Scoreboard bench for sel_box_render: render tasks queue the expected pixel
// stream, a negedge monitor pops and compares every written pixel.
module tb_sel_box_render;

    localparam int S   = 26;
    localparam int PER = 4 * (S - 1);

    logic       clk = 1'b0;
    logic       reset, start, mode;
    logic [8:0] base_x, x;
    logic [7:0] base_y, y;
    logic [3:0] box_x, box_y;
    logic [2:0] draw_colour, bg_colour, colour;
    logic       writeEn, busy, done;

    typedef struct {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        bit         first;
        bit         last;
    } pix_t;

    pix_t       exp_q[$];
    bit         seen[int];
    bit         dup_seen;
    int         checks = 0, passes = 0, done_cnt = 0;
    logic [8:0] prev_ox;
    logic [7:0] prev_oy;
    bit         prev_valid = 1'b0;

    sel_box_render #(.BOX_SIZE(S), .GRID_N(8), .IDX_W(4), .COLOUR_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .base_x(base_x), .base_y(base_y),
        .box_x(box_x), .box_y(box_y), .mode(mode), .draw_colour(draw_colour),
        .bg_colour(bg_colour), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // Expected pixel stream of one perimeter pass.
    task automatic push_pass(input logic [8:0] ox, input logic [7:0] oy, input logic [2:0] c);
        pix_t p;
        for (int ed = 0; ed < 4; ed++) begin
            for (int st = 0; st <= S - 2; st++) begin
                case (ed)
                    0: begin p.x = ox + 9'(st);               p.y = oy;                        end
                    1: begin p.x = ox + 9'(S - 1);            p.y = oy + 8'(st);               end
                    2: begin p.x = ox + 9'(S - 1) - 9'(st);   p.y = oy + 8'(S - 1);            end
                    default: begin p.x = ox;                  p.y = oy + 8'(S - 1) - 8'(st);   end
                endcase
                p.c     = c;
                p.first = (ed == 0 && st == 0);
                p.last  = (ed == 3 && st == S - 2);
                exp_q.push_back(p);
            end
        end
    endtask

    // Monitor: compare each written pixel in order, track per-pass coordinate set.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (writeEn) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_pixel", {x, y}, 0);
                end else begin
                    pix_t p;
                    int   key;
                    p = exp_q.pop_front();
                    if (p.first) begin
                        seen.delete();
                        dup_seen = 1'b0;
                    end
                    key = {15'd0, x, y};
                    if (seen.exists(key)) dup_seen = 1'b1;
                    seen[key] = 1'b1;
                    chk({x, y, colour} == {p.x, p.y, p.c}, "pixel", {x, y, colour}, {p.x, p.y, p.c});
                    if (p.last)
                        chk(seen.num() == PER && !dup_seen, "perimeter_set", seen.num(), PER);
                end
            end
        end
    end

    // One render request; eox/eoy are the hand-computed draw origin.
    task automatic render(input logic [8:0] bxb, input logic [7:0] byb, input logic [3:0] bx,
                          input logic [3:0] by, input logic md, input logic [2:0] dc,
                          input logic [2:0] bc, input logic [8:0] eox, input logic [7:0] eoy,
                          input bit pulse_busy, input int abort_at);
        bit er;
        int lat, npix, d0;
        bit got_done;
        er       = (md == 1'b0) && prev_valid;
        lat      = er ? 2 * PER + 1 : PER + 1;
        npix     = 0;
        d0       = done_cnt;
        got_done = 1'b0;
        if (er) push_pass(prev_ox, prev_oy, bc);
        push_pass(eox, eoy, dc);
        @(negedge clk);
        base_x = bxb; base_y = byb; box_x = bx; box_y = by;
        mode = md; draw_colour = dc; bg_colour = bc; start = 1'b1;
        for (int cyc = 1; cyc <= lat + 20; cyc++) begin
            @(negedge clk);
            if (writeEn) npix++;
            start = pulse_busy && (cyc == 10 || cyc == lat);
            if (cyc == 1) chk(busy && writeEn, "busy_first_cycle", {busy, writeEn}, 2'b11);
            if (cyc == 2) begin
                base_x = 9'($urandom); base_y = 8'($urandom); box_x = 4'($urandom);
                box_y = 4'($urandom); mode = ~md; draw_colour = ~dc; bg_colour = ~bc;
            end
            if (abort_at > 0 && npix == abort_at) begin
                #1 reset = 1'b1;
                #1 chk({writeEn, busy, done, x, y, colour} == '0, "abort_outputs",
                       {writeEn, busy, done, x, y, colour}, 0);
                exp_q.delete();
                prev_valid = 1'b0;
                start      = 1'b0;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (done) begin
                chk(cyc == lat, "latency", cyc, lat);
                got_done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!got_done) chk(1'b0, "done_timeout", 0, lat);
        chk(npix == lat - 1, "write_count", npix, lat - 1);
        repeat (6) @(negedge clk);
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        chk(done_cnt - d0 == 1 && !busy && !writeEn, "one_done_idle",
            {done_cnt - d0, busy, writeEn}, 32'h4);
        prev_ox    = eox;
        prev_oy    = eoy;
        prev_valid = 1'b1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        base_x = '0; base_y = '0; box_x = '0; box_y = '0;
        draw_colour = '0; bg_colour = '0;
        #12;
        chk({writeEn, busy, done, x, y, colour} == '0, "reset_state",
            {writeEn, busy, done, x, y, colour}, 0);
        @(negedge clk) reset = 1'b0;

        // first render: no erase, origin = base
        render(9'd10, 8'd5, 4'd0, 4'd0, 1'b0, 3'b100, 3'b000, 9'd10, 8'd5, 1'b0, 0);
        // erase (10,5) then draw at 10+2*26, 5+1*26
        render(9'd10, 8'd5, 4'd2, 4'd1, 1'b0, 3'b010, 3'b000, 9'd62, 8'd31, 1'b0, 0);
        // box_x=9 clamps to 7: 10+7*26 = 192; draw only, starts pulsed while busy
        render(9'd10, 8'd5, 4'd9, 4'd0, 1'b1, 3'b111, 3'b001, 9'd192, 8'd5, 1'b1, 0);
        // origin wraps: 500+26 = 14 (mod 512), 250+26 = 20 (mod 256)
        render(9'd500, 8'd250, 4'd1, 4'd1, 1'b1, 3'b011, 3'b000, 9'd14, 8'd20, 1'b0, 0);
        // reset at draw pixel 40
        render(9'd10, 8'd5, 4'd3, 4'd3, 1'b1, 3'b101, 3'b000, 9'd88, 8'd83, 1'b0, 40);
        // after reset mode 0 draws only
        render(9'd10, 8'd5, 4'd1, 4'd0, 1'b0, 3'b110, 3'b001, 9'd36, 8'd5, 1'b0, 0);
        // erase (36,5) in colour 7, draw at 10+4*26, 5+2*26
        render(9'd10, 8'd5, 4'd4, 4'd2, 1'b0, 3'b010, 3'b111, 9'd114, 8'd57, 1'b0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
